// File: rtl/plru_state_array.sv
// plru_state_array
//   Per-set storage of tree-PLRU bits for a set-associative cache. The read
//   port feeds the PLRU manager's lru input; the manager's new_lru returns on
//   the update port. After reset every set is cleared by a one-set-per-cycle
//   init sweep, then registered reads (latency 1) and writes are serviced.
//
//   Optional build macro: PLRU_BYPASS_EN
//     defined   : same-edge read+update of one index returns upd_lru (write-first)
//     undefined : that read returns the pre-update stored value (read-first)
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   ready         high once the init sweep has completed
//   rd_valid      read request this cycle
//   rd_index      set to read
//   rd_lru_valid  rd_lru holds the result of last cycle's read
//   rd_lru        PLRU bits of the set requested the previous cycle
//   upd_valid     write request this cycle
//   upd_index     set to write
//   upd_lru       new PLRU bits for upd_index
module plru_state_array #(
  parameter int s_index = 3,
  parameter int s_way   = 2,
  localparam int lru_w  = 2**s_way - 1
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               ready,
  input  logic               rd_valid,
  input  logic [s_index-1:0] rd_index,
  output logic               rd_lru_valid,
  output logic [lru_w-1:0]   rd_lru,
  input  logic               upd_valid,
  input  logic [s_index-1:0] upd_index,
  input  logic [lru_w-1:0]   upd_lru
);

  localparam int num_sets = 2**s_index;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [s_index-1:0] counter;
  logic [lru_w-1:0]   mem [num_sets];

  logic               rd_fire;
  logic               upd_fire;
  logic               sweep_last;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and request qualification
  always_comb begin
    state_next = state;
    rd_fire    = 1'b0;
    upd_fire   = 1'b0;
    sweep_last = &counter;
    unique case (state)
      INIT: begin
        if (sweep_last) begin
          state_next = RUN;
        end
      end
      RUN: begin
        rd_fire  = rd_valid;
        upd_fire = upd_valid;
      end
      default: state_next = INIT;
    endcase
  end

  assign ready = (state == RUN);

  // Sweep counter: only advances in INIT; its value is irrelevant once RUN is reached
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      counter <= '0;
    end else if (state == INIT) begin
      counter <= counter + 1'b1;
    end
  end

  // Array write port; contents untouched while rst_n is low
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == INIT) begin
        mem[counter] <= '0;
      end else if (upd_fire) begin
        mem[upd_index] <= upd_lru;
      end
    end
  end

  // Registered read port. The non-blocking array read sees the pre-update
  // value when an update to the same index lands on this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_lru_valid <= 1'b0;
      rd_lru       <= '0;
    end else begin
      rd_lru_valid <= rd_fire;
      if (rd_fire) begin
`ifdef PLRU_BYPASS_EN
        if (upd_fire && (upd_index == rd_index)) begin
          rd_lru <= upd_lru;
        end else begin
          rd_lru <= mem[rd_index];
        end
`else
        rd_lru <= mem[rd_index];
`endif
      end
    end
  end

endmodule

// File: tb/tb_plru_state_array.sv
module tb_plru_state_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ready;
  logic       rd_valid;
  logic [2:0] rd_index;
  logic       rd_lru_valid;
  logic [2:0] rd_lru;
  logic       upd_valid;
  logic [2:0] upd_index;
  logic [2:0] upd_lru;

  plru_state_array #(.s_index(3), .s_way(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ready        (ready),
    .rd_valid     (rd_valid),
    .rd_index     (rd_index),
    .rd_lru_valid (rd_lru_valid),
    .rd_lru       (rd_lru),
    .upd_valid    (upd_valid),
    .upd_index    (upd_index),
    .upd_lru      (upd_lru)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned due;
    logic [2:0]  val;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          nvec = 0;
  int          nerr = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: a read result is due exactly one cycle after issue; any other
  // cycle must show rd_lru_valid low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        exp_t e;
        e = sb.pop_front();
        nvec++;
        if (rd_lru_valid !== 1'b1 || rd_lru !== e.val) begin
          nerr++;
          $display("FAIL rd_result cyc=%0d: got valid=%b lru=%b, expected valid=1 lru=%b",
                   cyc, rd_lru_valid, rd_lru, e.val);
        end
      end else begin
        nvec++;
        if (rd_lru_valid !== 1'b0) begin
          nerr++;
          $display("FAIL rd_idle cyc=%0d: got valid=%b, expected valid=0", cyc, rd_lru_valid);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  task automatic push_read(input logic [2:0] idx, input logic [2:0] exp);
    rd_valid = 1'b1;
    rd_index = idx;
    sb.push_back('{due: cyc + 1, val: exp});
  endtask

  task automatic read1(input logic [2:0] idx, input logic [2:0] exp);
    push_read(idx, exp);
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic upd1(input logic [2:0] idx, input logic [2:0] val);
    upd_valid = 1'b1;
    upd_index = idx;
    upd_lru   = val;
    tick();
    upd_valid = 1'b0;
  endtask

  // Ready low for exactly 8 cycles after release; test-5 stray requests in cycle 3
  task automatic release_and_sweep(input bit stray);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ready_low_%0d", i), {2'b0, ready}, 3'b000);
      if (stray && i == 3) begin
        upd_valid = 1'b1; upd_index = 3'd7; upd_lru = 3'b111;
        rd_valid  = 1'b1; rd_index  = 3'd0;
      end
      tick();
      upd_valid = 1'b0;
      rd_valid  = 1'b0;
    end
    chk("ready_high", {2'b0, ready}, 3'b001);
  endtask

  initial begin
    rst_n = 1'b0; rd_valid = 1'b0; rd_index = '0;
    upd_valid = 1'b0; upd_index = '0; upd_lru = '0;
    tick(); tick();
    mon_en = 1'b1;
    chk("rst_ready", {2'b0, ready}, 3'b000);
    chk("rst_rd_lru", rd_lru, 3'b000);

    // Tests 1 and 5
    release_and_sweep(1'b1);
    for (int s = 0; s < 8; s++) push_read_and_tick(s[2:0]);
    rd_valid = 1'b0;
    tick();

    // Test 2
    upd1(3'd5, 3'b101);
    read1(3'd5, 3'b101);
    tick();
    read1(3'd4, 3'b000);
    tick();

    // Test 3
    upd_valid = 1'b1; upd_index = 3'd2; upd_lru = 3'b011;
`ifdef PLRU_BYPASS_EN
    read1(3'd2, 3'b011);
`else
    read1(3'd2, 3'b000);
`endif
    upd_valid = 1'b0;
    read1(3'd2, 3'b011);

    // Test 4
    upd_valid = 1'b1; upd_index = 3'd1; upd_lru = 3'b110;
    read1(3'd6, 3'b000);
    upd_valid = 1'b0;
    read1(3'd1, 3'b110);

    // Test 5 follow-up: stray INIT update must not have landed
    read1(3'd7, 3'b000);
    tick();

    // Test 6: mid-operation reset with a read issued on the reset edge
    upd1(3'd3, 3'b111);
    upd1(3'd0, 3'b010);
    read1(3'd3, 3'b111);
    rd_valid = 1'b1; rd_index = 3'd0; rst_n = 1'b0;
    tick();
    rd_valid = 1'b0;
    chk("mid_rst_valid", {2'b0, rd_lru_valid}, 3'b000);
    chk("mid_rst_rd_lru", rd_lru, 3'b000);
    release_and_sweep(1'b0);
    for (int s = 0; s < 8; s++) push_read_and_tick(s[2:0]);
    rd_valid = 1'b0;
    tick(); tick(); tick();

    nvec++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  task automatic push_read_and_tick(input logic [2:0] idx);
    push_read(idx, 3'b000);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
